// File: rtl/lsu_store_buffer_pkg.sv
// Shared LSU definitions: access size encodings and lane-select helpers
// used by the store buffer and reused by the load path.
package lsu_store_buffer_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } size_e;

  localparam int unsigned LANES = 4;

  // Big-endian byte enables: bit 3 is byte offset 00.
  function automatic logic [3:0] byte_sel(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] sel;
    sel = 4'b0000;
    case (size)
      SIZE_B: sel = 4'b1000 >> a;
      SIZE_H: begin
        if (a == 2'b00)      sel = 4'b1100;
        else if (a == 2'b10) sel = 4'b0011;
      end
      SIZE_W: if (a == 2'b00) sel = 4'b1111;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

  // Size 11 is not a legal encoding and is reported like a misalignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == SIZE_H) && a[0]) ||
           ((size == SIZE_W) && (a != 2'b00)) ||
           (size == 2'b11);
  endfunction

endpackage

// File: rtl/lsu_store_buffer_if.sv
// Store-side, load-hazard and data-bus signals of the store buffer.
interface lsu_store_buffer_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 32
);
  logic             st_valid;
  logic             st_ready;
  logic [AW-1:0]    st_addr;
  logic [1:0]       st_size;
  logic [WIDTH-1:0] st_data;
  logic             st_align_err;
  logic [AW-1:0]    ld_addr;
  logic             ld_hit;
  logic             dbus_req;
  logic [AW-1:0]    dbus_addr;
  logic [WIDTH-1:0] dbus_data;
  logic [3:0]       dbus_sel;
  logic             dbus_ack;
  logic             dbus_err;
  logic             sb_empty;
  logic             sb_err;
  logic [AW-1:0]    sb_err_addr;

  // Buffer side.
  modport slave (
    input  st_valid, st_addr, st_size, st_data, ld_addr, dbus_ack, dbus_err,
    output st_ready, st_align_err, ld_hit, dbus_req, dbus_addr, dbus_data,
           dbus_sel, sb_empty, sb_err, sb_err_addr
  );

  // LSU / bus side.
  modport master (
    output st_valid, st_addr, st_size, st_data, ld_addr, dbus_ack, dbus_err,
    input  st_ready, st_align_err, ld_hit, dbus_req, dbus_addr, dbus_data,
           dbus_sel, sb_empty, sb_err, sb_err_addr
  );
endinterface

// File: rtl/lsu_sb_fifo.sv
// In-order store queue. Exposes per-entry valid bits and word addresses
// so the top can compare load addresses against every pending store.
module lsu_sb_fifo #(
  parameter int WIDTH = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [AW-1:0]              i_addr,
  input  logic [WIDTH-1:0]           i_data,
  input  logic [3:0]                 i_sel,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [AW-1:0]              o_head_addr,
  output logic [WIDTH-1:0]           o_head_data,
  output logic [3:0]                 o_head_sel,
  output logic [DEPTH-1:0]           o_valid,
  output logic [DEPTH-1:0][AW-3:0]   o_waddr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    r_addr [DEPTH];
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [3:0]       r_sel  [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointer and occupancy update; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Entry storage; cleared on reset so the bus outputs read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_sel[i]  <= '0;
      end
    end else if (w_push) begin
      r_addr[r_wr_ptr] <= i_addr;
      r_data[r_wr_ptr] <= i_data;
      r_sel[r_wr_ptr]  <= i_sel;
    end
  end

  assign o_head_addr = r_addr[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];
  assign o_head_sel  = r_sel[r_rd_ptr];

  // An entry is live when its distance from the read pointer is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PW-1:0] w_off;
    assign w_off      = PW'(g) - r_rd_ptr;
    assign o_valid[g] = ({1'b0, w_off} < r_count);
    assign o_waddr[g] = r_addr[g][AW-1:2];
  end

endmodule

// File: rtl/lsu_store_buffer.sv
// Posted-store buffer: derives byte selects, queues aligned stores,
// drains them in order over req/ack, flags load hazards, reports bus errors.
module lsu_store_buffer
  import lsu_store_buffer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  lsu_store_buffer_if.slave   sb
);
  logic                     w_full;
  logic                     w_empty;
  logic                     w_push;
  logic                     w_pop;
  logic [3:0]               w_sel;
  logic [AW-1:0]            w_head_addr;
  logic [DEPTH-1:0]         w_valid;
  logic [DEPTH-1:0][AW-3:0] w_waddr;
  logic                     r_sb_err;
  logic [AW-1:0]            r_sb_err_addr;

  assign sb.st_align_err = sb.st_valid && misaligned(sb.st_size, sb.st_addr[1:0]);
  assign sb.st_ready     = !w_full;
  assign w_sel           = byte_sel(sb.st_size, sb.st_addr[1:0]);
  assign w_push          = sb.st_valid && !w_full && !sb.st_align_err;
  assign w_pop           = sb.dbus_req && (sb.dbus_ack || sb.dbus_err);

  lsu_sb_fifo #(.WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_addr      (sb.st_addr),
    .i_data      (sb.st_data),
    .i_sel       (w_sel),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_addr (w_head_addr),
    .o_head_data (sb.dbus_data),
    .o_head_sel  (sb.dbus_sel),
    .o_valid     (w_valid),
    .o_waddr     (w_waddr)
  );

  assign sb.dbus_req  = !w_empty;
  assign sb.dbus_addr = {w_head_addr[AW-1:2], 2'b00};
  assign sb.sb_empty  = w_empty;

  // Load hazard: any live entry, including the head being acked now.
  always_comb begin
    sb.ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (w_waddr[i] == sb.ld_addr[AW-1:2])) sb.ld_hit = 1'b1;
    end
  end

  // Bus error: one-cycle pulse and capture of the failing byte address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_err      <= 1'b0;
      r_sb_err_addr <= '0;
    end else begin
      r_sb_err <= sb.dbus_req && sb.dbus_err;
      if (sb.dbus_req && sb.dbus_err) r_sb_err_addr <= w_head_addr;
    end
  end

  assign sb.sb_err      = r_sb_err;
  assign sb.sb_err_addr = r_sb_err_addr;

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Directed bench for lsu_store_buffer with hand-computed expectations.
module tb_lsu_store_buffer;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errs;

  lsu_store_buffer_if #(.WIDTH(32), .AW(32)) sb_if ();

  lsu_store_buffer #(.WIDTH(32), .AW(32), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are changed here, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_st(input logic v, input logic [31:0] a, input logic [1:0] s,
                          input logic [31:0] d);
    sb_if.st_valid = v;
    sb_if.st_addr  = a;
    sb_if.st_size  = s;
    sb_if.st_data  = d;
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    rst_n    = 1'b0;
    drive_st(1'b0, 32'h0, 2'b00, 32'h0);
    sb_if.ld_addr  = 32'h0;
    sb_if.dbus_ack = 1'b0;
    sb_if.dbus_err = 1'b0;
    #12;
    chk("rst_req",      sb_if.dbus_req,    1'b0);
    chk("rst_empty",    sb_if.sb_empty,    1'b1);
    chk("rst_ready",    sb_if.st_ready,    1'b1);
    chk("rst_err",      sb_if.sb_err,      1'b0);
    chk("rst_err_addr", sb_if.sb_err_addr, 32'h0);
    chk("rst_addr",     sb_if.dbus_addr,   32'h0);
    chk("rst_data",     sb_if.dbus_data,   32'h0);
    chk("rst_sel",      sb_if.dbus_sel,    4'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single word store, ack after two request cycles.
    drive_st(1'b1, 32'h1000, 2'b10, 32'hDEADBEEF);
    #1 chk("t1_no_bypass", sb_if.dbus_req, 1'b0);
    tick();
    drive_st(1'b0, 32'h0, 2'b00, 32'h0);
    chk("t1_req",   sb_if.dbus_req,  1'b1);
    chk("t1_addr",  sb_if.dbus_addr, 32'h1000);
    chk("t1_sel",   sb_if.dbus_sel,  4'b1111);
    chk("t1_data",  sb_if.dbus_data, 32'hDEADBEEF);
    chk("t1_empty", sb_if.sb_empty,  1'b0);
    tick();
    chk("t1_req_hold",  sb_if.dbus_req,  1'b1);
    chk("t1_addr_hold", sb_if.dbus_addr, 32'h1000);
    sb_if.dbus_ack = 1'b1;
    tick();
    sb_if.dbus_ack = 1'b0;
    chk("t1_req_done",   sb_if.dbus_req, 1'b0);
    chk("t1_empty_done", sb_if.sb_empty, 1'b1);

    // Byte, byte, half into the same word.
    drive_st(1'b1, 32'h2001, 2'b00, 32'h00AA0000);
    tick();
    drive_st(1'b1, 32'h2003, 2'b00, 32'h000000BB);
    tick();
    drive_st(1'b1, 32'h2002, 2'b01, 32'h0000CCDD);
    tick();
    drive_st(1'b0, 32'h0, 2'b00, 32'h0);
    chk("t2_sel0",  sb_if.dbus_sel,  4'b0100);
    chk("t2_addr0", sb_if.dbus_addr, 32'h2000);
    chk("t2_data0", sb_if.dbus_data, 32'h00AA0000);
    sb_if.dbus_ack = 1'b1;
    tick();
    chk("t2_sel1",  sb_if.dbus_sel,  4'b0001);
    chk("t2_addr1", sb_if.dbus_addr, 32'h2000);
    tick();
    chk("t2_sel2",  sb_if.dbus_sel,  4'b0011);
    chk("t2_addr2", sb_if.dbus_addr, 32'h2000);
    chk("t2_data2", sb_if.dbus_data, 32'h0000CCDD);
    tick();
    sb_if.dbus_ack = 1'b0;
    chk("t2_empty", sb_if.sb_empty, 1'b1);

    // Five stores against a stalled bus.
    for (int i = 0; i < 4; i++) begin
      drive_st(1'b1, 32'h5000 + 32'(4 * i), 2'b10, 32'(i));
      #1 chk($sformatf("t3_ready%0d", i), sb_if.st_ready, 1'b1);
      tick();
    end
    drive_st(1'b1, 32'h5010, 2'b10, 32'd4);
    sb_if.dbus_ack = 1'b1;
    #1;
    chk("t3_full_ready", sb_if.st_ready,  1'b0);
    chk("t3_head0",      sb_if.dbus_addr, 32'h5000);
    tick();
    chk("t3_ready_after_pop", sb_if.st_ready,  1'b1);
    chk("t3_head1",           sb_if.dbus_addr, 32'h5004);
    chk("t3_req1",            sb_if.dbus_req,  1'b1);
    tick();
    drive_st(1'b0, 32'h0, 2'b00, 32'h0);
    chk("t3_head2", sb_if.dbus_addr, 32'h5008);
    chk("t3_data2", sb_if.dbus_data, 32'd2);
    tick();
    chk("t3_head3", sb_if.dbus_addr, 32'h500C);
    chk("t3_data3", sb_if.dbus_data, 32'd3);
    tick();
    chk("t3_head4", sb_if.dbus_addr, 32'h5010);
    chk("t3_data4", sb_if.dbus_data, 32'd4);
    chk("t3_req4",  sb_if.dbus_req,  1'b1);
    tick();
    sb_if.dbus_ack = 1'b0;
    chk("t3_empty", sb_if.sb_empty, 1'b1);

    // Alignment errors are flagged and dropped.
    drive_st(1'b1, 32'h3001, 2'b00, 32'h0);
    #1 chk("t4_byte_ok", sb_if.st_align_err, 1'b0);
    sb_if.st_valid = 1'b0;
    drive_st(1'b1, 32'h3001, 2'b01, 32'h11111111);
    #1 chk("t4_half_mis", sb_if.st_align_err, 1'b1);
    tick();
    drive_st(1'b1, 32'h3002, 2'b10, 32'h22222222);
    #1 chk("t4_word_mis", sb_if.st_align_err, 1'b1);
    tick();
    drive_st(1'b1, 32'h3000, 2'b11, 32'h33333333);
    #1 chk("t4_size11", sb_if.st_align_err, 1'b1);
    tick();
    drive_st(1'b0, 32'h0, 2'b00, 32'h0);
    #1;
    chk("t4_empty",   sb_if.sb_empty,     1'b1);
    chk("t4_req",     sb_if.dbus_req,     1'b0);
    chk("t4_noerr",   sb_if.st_align_err, 1'b0);

    // Load hazard against a pending store.
    drive_st(1'b1, 32'h4004, 2'b10, 32'h44444444);
    sb_if.ld_addr = 32'h4007;
    #1 chk("t5_no_same_cycle", sb_if.ld_hit, 1'b0);
    tick();
    drive_st(1'b0, 32'h0, 2'b00, 32'h0);
    #1 chk("t5_hit", sb_if.ld_hit, 1'b1);
    sb_if.ld_addr = 32'h4008;
    #1 chk("t5_miss", sb_if.ld_hit, 1'b0);
    sb_if.ld_addr = 32'h4007;
    sb_if.dbus_ack = 1'b1;
    #1 chk("t5_hit_popping", sb_if.ld_hit, 1'b1);
    tick();
    sb_if.dbus_ack = 1'b0;
    #1 chk("t5_after_ack", sb_if.ld_hit, 1'b0);

    // Bus error on the first of two entries.
    drive_st(1'b1, 32'h6001, 2'b00, 32'h00550000);
    tick();
    drive_st(1'b1, 32'h6004, 2'b10, 32'h66666666);
    tick();
    drive_st(1'b0, 32'h0, 2'b00, 32'h0);
    chk("t6_err_pre", sb_if.sb_err, 1'b0);
    sb_if.dbus_err = 1'b1;
    tick();
    sb_if.dbus_err = 1'b0;
    chk("t6_err_pulse", sb_if.sb_err,      1'b1);
    chk("t6_err_addr",  sb_if.sb_err_addr, 32'h6001);
    chk("t6_next_addr", sb_if.dbus_addr,   32'h6004);
    chk("t6_next_req",  sb_if.dbus_req,    1'b1);
    tick();
    chk("t6_err_fall",      sb_if.sb_err,      1'b0);
    chk("t6_err_addr_hold", sb_if.sb_err_addr, 32'h6001);
    sb_if.dbus_ack = 1'b1;
    tick();
    sb_if.dbus_ack = 1'b0;
    chk("t6_empty", sb_if.sb_empty, 1'b1);
    chk("t6_noerr", sb_if.sb_err,   1'b0);

    // Reset in the middle of a request.
    drive_st(1'b1, 32'h7000, 2'b10, 32'h77777777);
    tick();
    drive_st(1'b0, 32'h0, 2'b00, 32'h0);
    chk("t7_req", sb_if.dbus_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_req_drop",  sb_if.dbus_req,    1'b0);
    chk("t7_empty",     sb_if.sb_empty,    1'b1);
    chk("t7_addr_zero", sb_if.dbus_addr,   32'h0);
    chk("t7_err_addr",  sb_if.sb_err_addr, 32'h0);
    sb_if.dbus_ack = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    sb_if.dbus_ack = 1'b0;
    chk("t7_post_empty", sb_if.sb_empty, 1'b1);
    chk("t7_post_ready", sb_if.st_ready, 1'b1);
    drive_st(1'b1, 32'h8000, 2'b10, 32'h88888888);
    tick();
    drive_st(1'b0, 32'h0, 2'b00, 32'h0);
    chk("t7_new_addr", sb_if.dbus_addr, 32'h8000);
    chk("t7_new_data", sb_if.dbus_data, 32'h88888888);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
